bsg_nor2_rr_share: RTL and testbench
====================================

Name: bsg_nor2_rr_share

Overview:
- Shares one width_p-bit bitwise NOR unit among els_p requesters.
- Each requester presents an operand pair under a valid/ready handshake. A round-robin arbiter grants one requester per cycle, and the NOR result is captured into a one-entry output register tagged with the requester id.
- Sits between multiple client pipelines and a single downstream consumer that acknowledges with yumi.

Parameters:
- width_p, 33, operand/result width in bits.
- els_p, 4, number of requesters (>=2).
- tag_width_lp, max(1, ceil(log2(els_p))), width of the requester id (localparam).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  els_p  per-requester valid.
- a_i  in  els_p*width_p  operand A; requester i occupies bits [i*width_p +: width_p].
- b_i  in  els_p*width_p  operand B; same packing as a_i.
- ready_o  out  els_p  one-hot (or zero) grant/accept; transfer on v_i[i] & ready_o[i].
- v_o  out  1  output register holds a result.
- data_o  out  width_p  equals ~(a | b) of the accepted pair.
- tag_o  out  tag_width_lp  index of the requester that produced data_o.
- yumi_i  in  1  consumer takes the output this cycle; legal only when v_o=1.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the posedge of clk_i.
  - reset_i is synchronous and active-high.
  - On reset: v_o=0; data_o=0; tag_o=0; round-robin pointer=0 (requester 0 has highest priority).
  - ready_o is combinational and is 0 while reset_i=1.
  - Reset mid-transaction drops the buffered result; no output is produced.
- Slot availability:
  - free = ~v_o | yumi_i. Dequeue and enqueue in the same cycle are allowed, giving full throughput of 1 result per cycle.
- Arbitration:
  - When free=1, grant the first requester with v_i=1, searching from index ptr upward and wrapping modulo els_p.
  - ready_o has exactly that requester's bit set; all other bits are 0.
  - When free=0 or no v_i is set, ready_o=0.
  - ready_o depends on v_i combinationally. Requesters must not make v_i depend on ready_o.
- Pointer update:
  - Only on a grant: ptr <= (granted+1) mod els_p.
  - ptr holds otherwise, including while stalled.
- Capture:
  - On a grant: data_o <= ~(a_g | b_g), tag_o <= g, v_o <= 1. Result is visible the cycle after acceptance (latency 1).
  - Else if yumi_i: v_o <= 0; data_o and tag_o hold their stale values.
- Backpressure:
  - While v_o=1 and yumi_i=0, data_o and tag_o are stable and ready_o=0.
- Assertions (simulation only):
  - yumi_i with v_o=0 is an error.
  - ready_o is at most one-hot.
- Boundary cases:
  - All requesters valid continuously → grants rotate 0,1,…,els_p-1,0.
  - A single requester valid → it is granted every free cycle regardless of ptr.
  - ptr at els_p-1 wraps to 0.
- Implied state: two states (EMPTY: v_o=0; FULL: v_o=1).
  - EMPTY→FULL on grant.
  - FULL→EMPTY on yumi_i without grant.
  - FULL→FULL on yumi_i with grant, or when stalled.

Decomposition:
- No package types are needed. tag width is derived locally with the standard safe clog2 helper.
- One sub-module: bsg_nor2_rr_arb.
  - Inputs: reqs_i, en_i (=free), clk_i, reset_i.
  - Outputs: grants_o one-hot, tag_o, v_o.
  - Owns the ptr register and its update.
- The top level owns the operand mux, the NOR, and the output register.

Test Plan:
- Reset: assert reset_i 2 cycles with all v_i=1 → ready_o=0 during reset; v_o=0, data_o=0, tag_o=0 after reset.
- Single op, els_p=4: v_i=4'b0100, a_i slice2=33'h0_0000_00F0, b_i slice2=33'h0_0000_000F, yumi_i=1 next cycle → ready_o=4'b0100 in cycle 0; cycle 1 v_o=1, tag_o=2, data_o=33'h1_FFFF_FF00.
- Fairness: v_i=4'b1111 held, yumi_i=1 whenever v_o=1 → tag_o sequence 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
- Backpressure: output full, yumi_i=0 for 5 cycles, v_i=4'b0011 → ready_o=0 and data_o/tag_o unchanged; first yumi cycle grants the next requester in pointer order.
- Wrap and skip: ptr=3, v_i=4'b0010 → grant requester 1; next ptr=2; then v_i=4'b1001 → grant 3, then 0.
- Mid-op reset: output full, reset_i pulsed 1 cycle → v_o=0 next cycle; after reset, v_i=4'b1111 grants requester 0 first.

Source files
------------

// File: rtl/bsg_nor2_rr_share_pkg.sv
// Shared helpers for the bsg_nor2_rr_share block.
//   safe_clog2   : index width for an N-entry set, never less than 1 bit
//   slot_state_e : occupancy of the one-entry output register
`timescale 1ns/1ps
package bsg_nor2_rr_share_pkg;

  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/bsg_nor2_rr_arb.sv
// Round-robin arbiter. Grants the first asserted request found when
// searching upward from ptr (with wrap-around). The pointer moves one
// past the winner on every grant and holds otherwise.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   reqs_i         : per-requester request
//   en_i           : a grant may be issued this cycle
//   grants_o       : one-hot (or zero) grant
//   tag_o          : index of the granted requester
//   v_o            : a grant is issued this cycle
`timescale 1ns/1ps
module bsg_nor2_rr_arb
  import bsg_nor2_rr_share_pkg::*;
#(
  parameter  int els_p        = 4,
  localparam int tag_width_lp = safe_clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [els_p-1:0]        reqs_i,
  input  logic                    en_i,
  output logic [els_p-1:0]        grants_o,
  output logic [tag_width_lp-1:0] tag_o,
  output logic                    v_o
);

  logic [tag_width_lp-1:0] ptr_q, ptr_d;
  logic [tag_width_lp:0]   cand;

  // NOTE: every combinationally assigned signal gets a default at the top
  // of the block so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    grants_o = '0;
    tag_o    = '0;
    v_o      = 1'b0;
    cand     = '0;
    if (en_i && !reset_i) begin
      // Walk offsets from farthest to nearest: the last hit is the one
      // closest to ptr, which is the round-robin winner.
      for (int i = els_p - 1; i >= 0; i--) begin
        cand = {1'b0, ptr_q} + (tag_width_lp + 1)'(i);
        if (cand >= (tag_width_lp + 1)'(els_p))
          cand = cand - (tag_width_lp + 1)'(els_p);
        if (reqs_i[cand[tag_width_lp-1:0]]) begin
          tag_o = cand[tag_width_lp-1:0];
          v_o   = 1'b1;
        end
      end
    end
    if (v_o)
      grants_o[tag_o] = 1'b1;
  end

  assign ptr_d = (tag_o == tag_width_lp'(els_p - 1)) ? '0
                                                      : tag_o + tag_width_lp'(1);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (reset_i)  ptr_q <= '0;
    else if (v_o) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bsg_nor2_rr_share.sv
// One width_p-bit bitwise NOR unit shared by els_p requesters. A round-robin
// arbiter accepts one operand pair per cycle into a one-entry output
// register tagged with the requester index; a downstream consumer drains
// it with yumi_i. Enqueue and dequeue may coincide, giving one result/cycle.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   v_i, ready_o   : per-requester valid / one-hot accept
//   a_i, b_i       : packed operands, requester i at [i*width_p +: width_p]
//   v_o            : output register holds a result
//   data_o, tag_o  : ~(a|b) of the accepted pair and its requester index
//   yumi_i         : consumer takes the result (only when v_o=1)
`timescale 1ns/1ps
module bsg_nor2_rr_share
  import bsg_nor2_rr_share_pkg::*;
#(
  parameter  int width_p      = 33,
  parameter  int els_p        = 4,
  localparam int tag_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [els_p-1:0]         v_i,
  input  logic [els_p*width_p-1:0] a_i,
  input  logic [els_p*width_p-1:0] b_i,
  output logic [els_p-1:0]         ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic [tag_width_lp-1:0]  tag_o,
  input  logic                     yumi_i
);

  slot_state_e             state_q, state_d;
  logic [width_p-1:0]      data_q, data_d;
  logic [tag_width_lp-1:0] tag_q, tag_d;
  logic [width_p-1:0]      a_sel, b_sel;
  logic [tag_width_lp-1:0] grant_tag;
  logic                    grant_v;
  logic                    free;

  assign v_o    = (state_q == FULL);
  assign data_o = data_q;
  assign tag_o  = tag_q;

  // The slot can accept when empty or when its current entry leaves now.
  assign free = !v_o || yumi_i;

  bsg_nor2_rr_arb #(.els_p(els_p)) arb (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .reqs_i   (v_i),
    .en_i     (free),
    .grants_o (ready_o),
    .tag_o    (grant_tag),
    .v_o      (grant_v)
  );

  // AND-OR operand mux steered by the one-hot grant.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < els_p; i++) begin
      if (ready_o[i]) begin
        a_sel = a_sel | a_i[i*width_p +: width_p];
        b_sel = b_sel | b_i[i*width_p +: width_p];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (grant_v) begin
      state_d = FULL;
      data_d  = ~(a_sel | b_sel);
      tag_d   = grant_tag;
    end else if (yumi_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o=0");
      assert ($onehot0(ready_o)) else $error("ready_o not at most one-hot");
    end
  end

endmodule

// File: tb/tb_bsg_nor2_rr_share.sv
`timescale 1ns/1ps
module tb_bsg_nor2_rr_share;

  localparam int W = 33;
  localparam int N = 4;
  localparam int T = 2;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [N-1:0]   v_i;
  logic [N*W-1:0] a_i, b_i;
  logic [N-1:0]   ready_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic [T-1:0]   tag_o;
  logic           yumi_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bsg_nor2_rr_share #(.width_p(W), .els_p(N)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .tag_o   (tag_o),
    .yumi_i  (yumi_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Registered outputs are sampled 1 ns after the rising edge; inputs are
  // changed at that same point and combinational ready_o is read 1 ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    v_i     = 4'b1111;
    yumi_i  = 1'b0;
    a_i     = '0;
    b_i     = '0;
    for (int i = 0; i < N; i++) a_i[i*W +: W] = W'(i);

    // Reset held two cycles with every requester valid.
    #1;
    check("ready_in_reset0", 64'(ready_o), 64'h0);
    tick();
    check("ready_in_reset1", 64'(ready_o), 64'h0);
    tick();
    check("rst_v_o",    64'(v_o),    64'h0);
    check("rst_data_o", 64'(data_o), 64'h0);
    check("rst_tag_o",  64'(tag_o),  64'h0);

    // Fairness: all valid, consume every result. Operand a of requester i
    // is i and b is 0, so data is ~i.
    reset_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      yumi_i = (k > 0);
      #1;
      check("fair_ready", 64'(ready_o), 64'(4'b0001 << (k % 4)));
      tick();
      check("fair_v_o",  64'(v_o),    64'h1);
      check("fair_tag",  64'(tag_o),  64'(k % 4));
      check("fair_data", 64'(data_o), 64'(33'h1_FFFF_FFFF - 33'(k % 4)));
    end

    // Backpressure: slot holds tag 1, ptr is 2, requesters 0 and 1 valid.
    v_i    = 4'b0011;
    yumi_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready", 64'(ready_o), 64'h0);
      tick();
      check("bp_v_o",  64'(v_o),    64'h1);
      check("bp_tag",  64'(tag_o),  64'h1);
      check("bp_data", 64'(data_o), 64'h1_FFFF_FFFE);
    end
    // Released: search 2,3,0 lands on requester 0.
    yumi_i = 1'b1;
    #1;
    check("bp_release_ready", 64'(ready_o), 64'b0001);
    tick();
    check("bp_release_tag",  64'(tag_o),  64'h0);
    check("bp_release_data", 64'(data_o), 64'h1_FFFF_FFFF);
    // Drain; ptr is now 1.
    v_i = 4'b0000;
    tick();
    check("drain_v_o", 64'(v_o), 64'h0);
    yumi_i = 1'b0;

    // Wrap and skip: grant 2 to move ptr to 3.
    v_i = 4'b0100;
    #1;
    check("wrap_setup_ready", 64'(ready_o), 64'b0100);
    tick();
    check("wrap_setup_tag", 64'(tag_o), 64'h2);
    yumi_i = 1'b1;
    v_i    = 4'b0010;
    #1;
    check("wrap_ready_r1", 64'(ready_o), 64'b0010);
    tick();
    check("wrap_tag_r1", 64'(tag_o), 64'h1);
    v_i = 4'b1001;
    #1;
    check("wrap_ready_r3", 64'(ready_o), 64'b1000);
    tick();
    check("wrap_tag_r3", 64'(tag_o), 64'h3);
    #1;
    check("wrap_ready_r0", 64'(ready_o), 64'b0001);
    tick();
    check("wrap_tag_r0", 64'(tag_o), 64'h0);

    // Single op from requester 2 (full-throughput enqueue while draining).
    a_i[2*W +: W] = 33'h0_0000_00F0;
    b_i[2*W +: W] = 33'h0_0000_000F;
    v_i = 4'b0100;
    #1;
    check("single_ready", 64'(ready_o), 64'b0100);
    tick();
    v_i    = 4'b0000;
    yumi_i = 1'b0;
    check("single_v_o",  64'(v_o),    64'h1);
    check("single_tag",  64'(tag_o),  64'h2);
    check("single_data", 64'(data_o), 64'h1_FFFF_FF00);

    // Mid-op reset: slot full, ptr at 3; reset drops the result.
    reset_i = 1'b1;
    v_i     = 4'b1111;
    #1;
    check("midrst_ready", 64'(ready_o), 64'h0);
    tick();
    check("midrst_v_o",  64'(v_o),    64'h0);
    check("midrst_tag",  64'(tag_o),  64'h0);
    check("midrst_data", 64'(data_o), 64'h0);
    reset_i = 1'b0;
    #1;
    check("post_rst_ready", 64'(ready_o), 64'b0001);
    tick();
    check("post_rst_v_o", 64'(v_o),   64'h1);
    check("post_rst_tag", 64'(tag_o), 64'h0);
    v_i    = 4'b0000;
    yumi_i = 1'b1;
    tick();
    check("final_drain_v_o", 64'(v_o), 64'h0);
    yumi_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
